// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding and BCD digit limit.
package bcd_down_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_down_timer_dec4.sv
// Combinational 4-digit BCD decrement with a zero flag on the result.
module bcd_dec4
   import bcd_down_timer_pkg::*;
(
   input  logic [15:0] value,
   output logic [15:0] result,
   output logic        zero
);

   logic borrow;

   // A digit at 0 becomes 9 and passes the borrow on; the first non-zero digit absorbs it.
   always_comb begin
      result = value;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (borrow) begin
            if (value[i*4 +: 4] == 4'd0) begin
               result[i*4 +: 4] = BCD_MAX;
            end else begin
               result[i*4 +: 4] = value[i*4 +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   assign zero = (result == 16'h0000);

endmodule

// File: rtl/smg.sv
// Seven-segment scan driver shared with the BCD up-counter: active-low anodes and segments.
module smg (
   input  logic [15:0] data,
   input  logic [1:0]  bitsel,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   logic [3:0] digit;
   logic [6:0] lit;

   always_comb begin
      an         = 4'b1111;
      an[bitsel] = 1'b0;
      digit      = data[{bitsel, 2'b00} +: 4];
      case (digit)
         4'd0:    lit = 7'h3F;
         4'd1:    lit = 7'h06;
         4'd2:    lit = 7'h5B;
         4'd3:    lit = 7'h4F;
         4'd4:    lit = 7'h66;
         4'd5:    lit = 7'h6D;
         4'd6:    lit = 7'h7D;
         4'd7:    lit = 7'h07;
         4'd8:    lit = 7'h7F;
         4'd9:    lit = 7'h6F;
         default: lit = 7'h00;
      endcase
      // Decimal point is never lit.
      seg = ~{1'b0, lit};
   end

endmodule

// File: rtl/bcd_down_timer.sv
// 4-digit BCD countdown timer with start/pause pulse control, done flag and SMG display output.
module bcd_down_timer
   import bcd_down_timer_pkg::*;
#(
   parameter int TICK_W = 22,
   parameter int SCAN_W = 16
)
(
   input  logic        CLK,
   input  logic        CLR,
   input  logic        LOAD,
   input  logic [15:0] LOAD_VAL,
   input  logic        SS,
   output logic        done,
   output logic        running,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   localparam logic [TICK_W-1:0] PRESC_ONE = {{(TICK_W-1){1'b0}}, 1'b1};
   localparam logic [SCAN_W-1:0] SCAN_ONE  = {{(SCAN_W-1){1'b0}}, 1'b1};

   state_t            state, state_next;
   logic [15:0]       count, count_dec;
   logic              dec_zero, count_zero, tick;
   logic [TICK_W-1:0] presc;
   logic [SCAN_W-1:0] scan;
   logic [1:0]        bitsel;

   function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++)
         r[i*4 +: 4] = (v[i*4 +: 4] > BCD_MAX) ? BCD_MAX : v[i*4 +: 4];
      return r;
   endfunction

   bcd_dec4 u_dec (
      .value  (count),
      .result (count_dec),
      .zero   (dec_zero)
   );

   smg u_smg (
      .data   (count),
      .bitsel (bitsel),
      .an     (an),
      .seg    (seg)
   );

   assign count_zero = (count == 16'h0000);
   // A pause request in RUN freezes the prescaler on that cycle, so no tick fires with it.
   assign tick = (state == ST_RUN) && !SS && !LOAD && (&presc);

   always_comb begin
      state_next = state;
      if (LOAD) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (SS) state_next = count_zero ? ST_DONE : ST_RUN;
            ST_RUN: begin
               if (SS)                                  state_next = ST_PAUSE;
               else if (tick && !count_zero && dec_zero) state_next = ST_DONE;
            end
            ST_PAUSE: if (SS) state_next = ST_RUN;
            ST_DONE:  if (SS) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state   <= ST_IDLE;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         running <= (state_next == ST_RUN);
         done    <= (state_next == ST_DONE);
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         count <= 16'h0000;
         presc <= '0;
      end else if (LOAD) begin
         count <= clamp_bcd(LOAD_VAL);
         presc <= '0;
      end else if (state == ST_RUN && !SS) begin
         presc <= presc + PRESC_ONE;
         if (tick && !count_zero) count <= count_dec;
      end
   end

   // Display scan runs in every state so the digits stay lit while idle or paused.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         scan   <= '0;
         bitsel <= 2'd0;
      end else begin
         scan <= scan + SCAN_ONE;
         if (&scan) bitsel <= bitsel + 2'd1;
      end
   end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: vector table, corner-case sequences and a random run against a decimal model.
module tb_bcd_down_timer;

   localparam int TICK_W = 2;
   localparam int SCAN_W = 2;
   localparam int PMAX   = (1 << TICK_W) - 1;
   localparam int SPER   = 1 << SCAN_W;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic        CLK = 1'b0;
   logic        CLR, LOAD, SS;
   logic [15:0] LOAD_VAL;
   logic        done, running;
   logic [3:0]  an;
   logic [7:0]  seg;

   int n_tests = 0, n_fail = 0;
   int m_cnt, m_pre, m_st, m_scan;

   typedef struct {
      logic        load;
      logic [15:0] val;
      logic        ss;
      logic [15:0] exp_count;
      logic        exp_done;
      logic        exp_run;
   } vec_t;

   vec_t vecs [11];

   bcd_down_timer #(.TICK_W(TICK_W), .SCAN_W(SCAN_W)) dut (
      .CLK      (CLK),
      .CLR      (CLR),
      .LOAD     (LOAD),
      .LOAD_VAL (LOAD_VAL),
      .SS       (SS),
      .done     (done),
      .running  (running),
      .an       (an),
      .seg      (seg)
   );

   always #5 CLK = ~CLK;

   function automatic int clamp_to_int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) begin
         int d = int'(v[i*4 +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic logic [15:0] int_to_bcd(input int n);
      logic [15:0] r;
      int k = n;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(k % 10);
         k = k / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_pre = 0; m_st = M_IDLE; m_scan = 0;
   endtask

   task automatic model_step(input logic ld, input logic [15:0] val, input logic s);
      m_scan++;
      if (ld) begin
         m_cnt = clamp_to_int(val);
         m_pre = 0;
         m_st  = M_IDLE;
      end else begin
         case (m_st)
            M_IDLE:  if (s) m_st = (m_cnt != 0) ? M_RUN : M_DONE;
            M_RUN: begin
               if (s) m_st = M_PAUSE;
               else if (m_pre == PMAX) begin
                  m_pre = 0;
                  if (m_cnt != 0) begin
                     m_cnt--;
                     if (m_cnt == 0) m_st = M_DONE;
                  end
               end else m_pre++;
            end
            M_PAUSE: if (s) m_st = M_RUN;
            default: if (s) m_st = M_IDLE;
         endcase
      end
   endtask

   task automatic check_model();
      int bs, pw, dg;
      logic [3:0] ea;
      bs = (m_scan / SPER) % 4;
      pw = 1;
      for (int i = 0; i < bs; i++) pw = pw * 10;
      dg = (m_cnt / pw) % 10;
      ea = 4'b1111;
      ea[bs] = 1'b0;
      chk("model_count", dut.count, int_to_bcd(m_cnt));
      chk("model_done", done, m_st == M_DONE);
      chk("model_running", running, m_st == M_RUN);
      chk("model_an", an, ea);
      chk("model_seg", seg, SEG_TAB[dg]);
   endtask

   task automatic cycle(input logic ld, input logic [15:0] val, input logic s);
      LOAD = ld; LOAD_VAL = val; SS = s;
      model_step(ld, val, s);
      @(posedge CLK); #1;
      LOAD = 1'b0; SS = 1'b0;
      check_model();
   endtask

   initial begin
      logic [15:0] seq [4];
      logic        ld, s;
      logic [15:0] v;
      seq = '{16'h0099, 16'h0098, 16'h0097, 16'h0096};

      vecs[0]  = '{1'b1, 16'h1A3F, 1'b1, 16'h1939, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 16'h0000, 1'b1, 16'h1939, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 16'hFFFF, 1'b0, 16'h9999, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 16'hC0DE, 1'b0, 16'h9099, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 16'h0000, 1'b1, 16'h9099, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 16'h0000, 1'b1, 16'h9099, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 16'h0010, 1'b1, 16'h0010, 1'b0, 1'b0};

      CLR = 1'b1; LOAD = 1'b0; SS = 1'b0; LOAD_VAL = 16'h0000;
      repeat (2) @(posedge CLK);
      #1;
      CLR = 1'b0;
      model_reset();
      chk("reset_count", dut.count, 16'h0000);
      chk("reset_done", done, 1'b0);
      chk("reset_running", running, 1'b0);
      chk("reset_an", an, 4'b1110);

      for (int k = 1; k <= 16; k++) begin
         cycle(1'b0, 16'h0000, 1'b0);
         chk("bitsel_step", dut.bitsel, (k / 4) % 4);
      end

      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].load, vecs[i].val, vecs[i].ss);
         chk("vec_count", dut.count, vecs[i].exp_count);
         chk("vec_done", done, vecs[i].exp_done);
         chk("vec_running", running, vecs[i].exp_run);
      end

      cycle(1'b1, 16'h0100, 1'b0);
      cycle(1'b0, 16'h0000, 1'b1);
      for (int t = 1; t <= 16; t++) begin
         cycle(1'b0, 16'h0000, 1'b0);
         if (t % 4 == 0) chk("borrow_seq", dut.count, seq[t/4 - 1]);
      end

      cycle(1'b1, 16'h0002, 1'b0);
      cycle(1'b0, 16'h0000, 1'b1);
      repeat (4) cycle(1'b0, 16'h0000, 1'b0);
      chk("end_0001", dut.count, 16'h0001);
      repeat (4) cycle(1'b0, 16'h0000, 1'b0);
      chk("end_0000", dut.count, 16'h0000);
      chk("end_done", done, 1'b1);
      chk("end_running", running, 1'b0);
      repeat (8) cycle(1'b0, 16'h0000, 1'b0);
      chk("end_hold", dut.count, 16'h0000);
      chk("end_done_hold", done, 1'b1);

      cycle(1'b1, 16'h0005, 1'b0);
      cycle(1'b0, 16'h0000, 1'b1);
      repeat (2) cycle(1'b0, 16'h0000, 1'b0);
      cycle(1'b0, 16'h0000, 1'b1);
      chk("pause_presc", dut.presc, 2);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 16'h0000, 1'b0);
         chk("pause_count", dut.count, 16'h0005);
         chk("pause_running", running, 1'b0);
      end
      cycle(1'b0, 16'h0000, 1'b1);
      cycle(1'b0, 16'h0000, 1'b0);
      chk("resume_wait", dut.count, 16'h0005);
      cycle(1'b0, 16'h0000, 1'b0);
      chk("resume_dec", dut.count, 16'h0004);

      cycle(1'b1, 16'h0042, 1'b0);
      cycle(1'b0, 16'h0000, 1'b1);
      repeat (5) cycle(1'b0, 16'h0000, 1'b0);
      CLR = 1'b1;
      #2;
      chk("clr_count", dut.count, 16'h0000);
      chk("clr_state", dut.state, 0);
      chk("clr_done", done, 1'b0);
      chk("clr_running", running, 1'b0);
      chk("clr_bitsel", dut.bitsel, 0);
      chk("clr_an", an, 4'b1110);
      #1;
      CLR = 1'b0;
      model_reset();

      for (int i = 0; i < 3000; i++) begin
         ld = ($urandom_range(0, 59) == 0);
         v  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
         s  = ($urandom_range(0, 7) == 0);
         cycle(ld, v, s);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
